button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Input-side counterpart to the LED-driving blink logic: turns a raw, bouncing, asynchronous push-button into clean single-cycle events and levels.
- Sits between the board button pin and user logic, in the PLL clock domain (clk0, 100 MHz).
- Provides a debounced level, press and release pulses, long-press detection, and a wrapping press counter.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); must be >= 2.
- LONG_CYCLES, 100000000, clocks after press acceptance before long_press fires (1 s); must be > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 0, 0: raw high = pressed; 1: raw low = pressed.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock (PLL CLK0)
- rst  input  1  synchronous active-low reset
- button  input  1  raw asynchronous button pin
- pressed  output  1  debounced level, 1 while the button is accepted as held
- press  output  1  one-cycle pulse on accepted press
- release  output  1  one-cycle pulse on accepted release
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES
- was_long  output  1  latched on release: 1 if that hold produced long_press; valid from the release pulse until the next press
- press_count  output  CNT_W  accepted presses, modulo 2^CNT_W

Behaviour:
- Reset: rst sampled low at a clk edge forces the FSM to IDLE. pressed, press, release, long_press, was_long = 0; press_count = 0; both synchronizer flops = inactive level; all counters = 0.
- Reset takes priority over all other activity, including mid-debounce or mid-hold. No events are emitted for an interrupted hold.
- If the button is held through reset release, it goes through normal debounce and press fires again.
- Input path:
  - 2-flop synchronizer, then polarity normalization to act (1 = pressed).
  - The FSM uses only act; raw button never reaches FSM logic.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - act=1 -> PRESS_WAIT, dcnt=1.
- PRESS_WAIT:
  - act=0 -> IDLE, dcnt=0; the glitch is dropped.
  - act=1 and dcnt==DEBOUNCE_CYCLES-1 -> PRESSED. In the same cycle: press=1, pressed=1, press_count+1 (wraps), hcnt=0, long_seen=0, was_long=0.
  - Otherwise dcnt+1.
- PRESSED:
  - act=1: hcnt increments, saturating at LONG_CYCLES.
  - When hcnt==LONG_CYCLES-1 and long_seen=0: long_press=1, long_seen=1. long_press fires exactly LONG_CYCLES clocks after press, once per hold.
  - act=0 -> RELEASE_WAIT, dcnt=1; hcnt frozen.
- RELEASE_WAIT:
  - act=1 -> PRESSED; hcnt resumes from its frozen value, pressed stays 1, no pulses.
  - act=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE. In the same cycle: release=1, pressed=0, was_long=long_seen.
  - Otherwise dcnt+1.
- Latency:
  - Edge 0 is the first clk edge at which raw button is sampled active, with the button stable afterwards.
  - press is high in the cycle following edge DEBOUNCE_CYCLES+1.
  - release is symmetric: high in the cycle following edge DEBOUNCE_CYCLES+1 after the raw release.
- Pulse properties:
  - press and release are never high in the same cycle.
  - long_press never coincides with press.
  - All pulses are registered and exactly one cycle wide.
- Counter widths: dcnt = $clog2(DEBOUNCE_CYCLES)+1, hcnt = $clog2(LONG_CYCLES)+1. No overflow is possible because hcnt saturates.

Decomposition:
- Shared header/package: FSM state encodings (localparams, 2-bit), and the helper function for counter width.
- One natural sub-module: sync_2ff. It is reused by later pin inputs and carries a parameterized reset value.
- The FSM and counters stay in button_conditioner.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=0.
- Clean press: raw 0->1 sampled at edge 0, held -> press=1 only in the cycle after edge 5; pressed=1 from then; press_count=1.
- Bounce rejection: raw toggles 1,0,1,0 on alternate edges, then stays 0 -> press never fires; pressed=0; press_count=0.
- Long press: hold 40 cycles -> long_press pulses exactly 20 clocks after press, once only; on release, release pulses and was_long=1.
- Short press with release bounce: hold 10 cycles, then 0,1,0 glitch on release -> single release pulse; was_long=0; no second press; press_count=1.
- Reset mid-hold: assert rst low for 1 cycle during PRESSED with raw still 1 -> all outputs 0, press_count=0; press re-fires 6 edges after rst returns high.
- Wrap and polarity: BTN_ACTIVE_LOW=1, CNT_W=2, 5 clean presses on raw low -> press_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Holds the FSM state encoding and the counter width helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs.
// The reset value lets each pin idle at its own inactive level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a clean level, press/release
// pulses, a one-shot long-press pulse and a wrapping press counter.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    output logic             pressed,
    output logic             press,
    output logic             release_o,
    output logic             long_press,
    output logic             was_long,
    output logic [CNT_W-1:0] press_count
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w(LONG_CYCLES);

    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

    localparam logic IDLE_LVL = (BTN_ACTIVE_LOW != 0);

    logic btn_sync;
    logic act;

    state_e           state_q;
    logic [DW-1:0]    dcnt_q;
    logic [HW-1:0]    hcnt_q;
    logic             long_seen_q;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             was_long_q;
    logic [CNT_W-1:0] count_q;

    sync_2ff #(
        .RESET_VAL(IDLE_LVL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(button),
        .q_o(btn_sync)
    );

    // act is 1 while the synchronized pin sits at its pressed level
    assign act = btn_sync ^ IDLE_LVL;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_seen_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            was_long_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (act) begin
                        state_q <= ST_PRESS_WAIT;
                        dcnt_q  <= D_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!act) begin
                        state_q <= ST_IDLE;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == D_LAST) begin
                        state_q     <= ST_PRESSED;
                        press_q     <= 1'b1;
                        pressed_q   <= 1'b1;
                        count_q     <= count_q + 1'b1;
                        hcnt_q      <= '0;
                        long_seen_q <= 1'b0;
                        was_long_q  <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (act) begin
                        if (hcnt_q != H_MAX) begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                        if (hcnt_q == H_LAST && !long_seen_q) begin
                            long_q      <= 1'b1;
                            long_seen_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_RELEASE_WAIT;
                        dcnt_q  <= D_ONE;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (act) begin
                        state_q <= ST_PRESSED;
                    end else if (dcnt_q == D_LAST) begin
                        state_q    <= ST_IDLE;
                        dcnt_q     <= '0;
                        release_q  <= 1'b1;
                        pressed_q  <= 1'b0;
                        was_long_q <= long_seen_q;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pressed     = pressed_q;
    assign press       = press_q;
    assign release_o   = release_q;
    assign long_press  = long_q;
    assign was_long    = was_long_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce latency, bounce,
// long press, release glitch, reset mid-hold, counter wrap/polarity.
module tb_button_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_btn;
    logic       a_pressed, a_press, a_release, a_long, a_was_long;
    logic [7:0] a_count;

    logic       b_rst, b_btn;
    logic       b_pressed, b_press, b_release, b_long, b_was_long;
    logic [1:0] b_count;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .BTN_ACTIVE_LOW(0),
        .CNT_W(8)
    ) dut_a (
        .clk(clk),
        .rst(a_rst),
        .button(a_btn),
        .pressed(a_pressed),
        .press(a_press),
        .release_o(a_release),
        .long_press(a_long),
        .was_long(a_was_long),
        .press_count(a_count)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .BTN_ACTIVE_LOW(1),
        .CNT_W(2)
    ) dut_b (
        .clk(clk),
        .rst(b_rst),
        .button(b_btn),
        .pressed(b_pressed),
        .press(b_press),
        .release_o(b_release),
        .long_press(b_long),
        .was_long(b_was_long),
        .press_count(b_count)
    );

    int checks = 0;
    int errors = 0;

    int ecnt, np, nr, nl, pe, re, le, ovl;

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear();
        ecnt = 0; np = 0; nr = 0; nl = 0;
        pe = -1; re = -1; le = -1;
    endtask

    // Edge index counts from the first edge after clear()
    task automatic run(input int n);
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            if (a_press) begin np++; pe = ecnt; end
            if (a_release) begin nr++; re = ecnt; end
            if (a_long) begin nl++; le = ecnt; end
            if (a_press && a_release) ovl++;
            if (a_press && a_long) ovl++;
            ecnt++;
        end
    endtask

    task automatic reset_a();
        a_rst = 1'b0;
        run(2);
        a_rst = 1'b1;
        run(1);
    endtask

    initial begin
        ovl = 0;
        clear();
        a_btn = 1'b0;
        b_btn = 1'b1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        run(3);
        chk("rst_pressed", a_pressed, 0);
        chk("rst_press", a_press, 0);
        chk("rst_release", a_release, 0);
        chk("rst_long", a_long, 0);
        chk("rst_was_long", a_was_long, 0);
        chk("rst_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_b_pressed", b_pressed, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        run(3);

        // clean press held into a long press
        clear();
        a_btn = 1'b1;
        run(46);
        chk("clean_np", np, 1);
        chk("clean_pe", pe, 5);
        chk("clean_pressed", a_pressed, 1);
        chk("clean_count", a_count, 1);
        chk("long_nl", nl, 1);
        chk("long_le", le, 25);
        clear();
        a_btn = 1'b0;
        run(8);
        chk("long_nr", nr, 1);
        chk("long_re", re, 5);
        chk("long_was_long", a_was_long, 1);
        chk("long_rel_pressed", a_pressed, 0);
        chk("long_rel_np", np, 0);
        chk("long_rel_nl", nl, 0);

        // bounce rejection
        reset_a();
        clear();
        for (int i = 0; i < 8; i++) begin
            a_btn = ((i % 4) < 2);
            run(1);
        end
        a_btn = 1'b0;
        run(10);
        chk("bounce_np", np, 0);
        chk("bounce_pressed", a_pressed, 0);
        chk("bounce_count", a_count, 0);

        // short press with a glitch on release
        reset_a();
        clear();
        a_btn = 1'b1;
        run(15);
        chk("short_np", np, 1);
        chk("short_nl", nl, 0);
        clear();
        a_btn = 1'b0;
        run(1);
        a_btn = 1'b1;
        run(1);
        a_btn = 1'b0;
        run(10);
        chk("short_nr", nr, 1);
        chk("short_re", re, 7);
        chk("short_np2", np, 0);
        chk("short_was_long", a_was_long, 0);
        chk("short_pressed", a_pressed, 0);
        chk("short_count", a_count, 1);

        // reset while held
        reset_a();
        clear();
        a_btn = 1'b1;
        run(12);
        chk("mid_pressed_pre", a_pressed, 1);
        clear();
        a_rst = 1'b0;
        run(1);
        a_rst = 1'b1;
        chk("mid_pressed", a_pressed, 0);
        chk("mid_press", a_press, 0);
        chk("mid_long", a_long, 0);
        chk("mid_was_long", a_was_long, 0);
        chk("mid_count", a_count, 0);
        run(9);
        chk("mid_np", np, 1);
        chk("mid_pe", pe, 6);
        chk("mid_nr", nr, 0);
        chk("mid_count2", a_count, 1);

        // active-low pin with a 2-bit wrapping counter
        for (int i = 0; i < 5; i++) begin
            b_btn = 1'b0;
            run(8);
            chk("wrap_count", b_count, wrap_exp[i]);
            chk("wrap_pressed", b_pressed, 1);
            b_btn = 1'b1;
            run(8);
            chk("wrap_released", b_pressed, 0);
        end

        chk("pulse_overlap", ovl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
